// File: rtl/sip_step_scheduler.sv
// Time-step scheduler for the synaptic input processor. For each step it takes one frame,
// scans every synapse through the SIP, flushes, and records the neuron spike.
module sip_step_scheduler #(
  parameter int unsigned N_SYN   = 16,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned N_STEPS = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic [N_SYN-1:0]   frame_spike,
  input  logic [N_SYN-1:0]   frame_ein,
  output logic               sip_write,
  output logic [SEL_W-1:0]   sip_select,
  output logic [N_SYN-1:0]   sip_spike_in,
  output logic [N_SYN-1:0]   sip_ein,
  output logic               sip_flush,
  input  logic               sip_spike,
  output logic               busy,
  output logic               done,
  output logic [SEL_W-1:0]   step_idx,
  output logic [N_STEPS-1:0] spike_train,
  output logic [CNT_W-1:0]   spike_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_FLUSH, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               write_q, write_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_SYN-1:0]   spike_in_q, spike_in_d;
  logic [N_SYN-1:0]   ein_q, ein_d;
  logic               flush_q, flush_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   step_q, step_d;
  logic [N_STEPS-1:0] train_q, train_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Outputs are registered alongside the state, so each is derived from the next state.
  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    write_d    = 1'b0;
    sel_d      = '0;
    spike_in_d = spike_in_q;
    ein_d      = ein_q;
    flush_d    = 1'b0;
    done_d     = 1'b0;
    step_d     = step_q;
    train_d    = train_q;
    count_d    = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ready_d = 1'b1;
          step_d  = '0;
          train_d = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (frame_valid && ready_q) begin
          state_d    = S_SCAN;
          write_d    = 1'b1;
          spike_in_d = frame_spike;
          ein_d      = frame_ein;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (sel_q == SEL_W'(N_SYN - 1)) begin
          state_d = S_FLUSH;
          flush_d = 1'b1;
        end else begin
          write_d = 1'b1;
          sel_d   = sel_q + SEL_W'(1);
        end
      end
      S_FLUSH: begin
        for (int unsigned k = 0; k < N_STEPS; k++) begin
          if (step_q == SEL_W'(k)) train_d[k] = sip_spike;
        end
        if (sip_spike && (count_q != '1)) count_d = count_q + CNT_W'(1);
        if (step_q == SEL_W'(N_STEPS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_LOAD;
          ready_d = 1'b1;
          step_d  = step_q + SEL_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides the whole step: nothing is latched, sampled or cleared this edge.
    if (abort) begin
      state_d    = S_IDLE;
      ready_d    = 1'b0;
      write_d    = 1'b0;
      sel_d      = '0;
      flush_d    = 1'b0;
      done_d     = 1'b0;
      spike_in_d = spike_in_q;
      ein_d      = ein_q;
      step_d     = step_q;
      train_d    = train_q;
      count_d    = count_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      write_q    <= 1'b0;
      sel_q      <= '0;
      spike_in_q <= '0;
      ein_q      <= '0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      train_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      spike_in_q <= spike_in_d;
      ein_q      <= ein_d;
      flush_q    <= flush_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_q     <= step_d;
      train_q    <= train_d;
      count_q    <= count_d;
    end
  end

  assign frame_ready  = ready_q;
  assign sip_write    = write_q;
  assign sip_select   = sel_q;
  assign sip_spike_in = spike_in_q;
  assign sip_ein      = ein_q;
  assign sip_flush    = flush_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign step_idx     = step_q;
  assign spike_train  = train_q;
  assign spike_count  = count_q;

endmodule

// File: tb/tb_sip_step_scheduler.sv
// Scoreboard bench for sip_step_scheduler: accepted frames and per-inference results are
// queued by the stimulus and consumed by a negedge monitor as the DUT presents them.
module tb_sip_step_scheduler;
  localparam int N_SYN    = 16;
  localparam int SEL_W    = 4;
  localparam int N_STEPS  = 8;
  localparam int CNT_W    = 4;
  localparam int STEP_CYC = N_SYN + 2;
  localparam int S_STEPS  = 15;

  logic clock = 1'b0;
  logic reset, start, abort, frame_valid, sip_spike;
  logic [N_SYN-1:0] frame_spike, frame_ein;
  logic frame_ready, sip_write, sip_flush, busy, done;
  logic [SEL_W-1:0] sip_select, step_idx;
  logic [N_SYN-1:0] sip_spike_in, sip_ein;
  logic [N_STEPS-1:0] spike_train;
  logic [CNT_W-1:0] spike_count;

  logic start_s;
  logic s_ready, s_write, s_flush, s_busy, s_done;
  logic [SEL_W-1:0] s_select, s_step;
  logic [N_SYN-1:0] s_spike_in, s_ein;
  logic [S_STEPS-1:0] s_train;
  logic [CNT_W-1:0] s_count;
  logic [N_SYN-1:0] s_frame = 16'h1234;

  sip_step_scheduler #(.N_SYN(N_SYN), .SEL_W(SEL_W), .N_STEPS(N_STEPS), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_spike(frame_spike), .frame_ein(frame_ein),
    .sip_write(sip_write), .sip_select(sip_select), .sip_spike_in(sip_spike_in),
    .sip_ein(sip_ein), .sip_flush(sip_flush), .sip_spike(sip_spike),
    .busy(busy), .done(done), .step_idx(step_idx),
    .spike_train(spike_train), .spike_count(spike_count));

  sip_step_scheduler #(.N_SYN(N_SYN), .SEL_W(SEL_W), .N_STEPS(S_STEPS), .CNT_W(CNT_W)) u_sat (
    .clock(clock), .reset(reset), .start(start_s), .abort(1'b0),
    .frame_valid(1'b1), .frame_ready(s_ready),
    .frame_spike(s_frame), .frame_ein(s_frame),
    .sip_write(s_write), .sip_select(s_select), .sip_spike_in(s_spike_in),
    .sip_ein(s_ein), .sip_flush(s_flush), .sip_spike(1'b1),
    .busy(s_busy), .done(s_done), .step_idx(s_step),
    .spike_train(s_train), .spike_count(s_count));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { logic [N_SYN-1:0] sp; logic [N_SYN-1:0] en; } frame_t;
  typedef struct { logic [15:0] train; logic [3:0] count; int cyc; } res_t;
  frame_t fq[$];
  res_t   dq[$];
  res_t   sq[$];

  // SIP neuron model: presents the planned spike for the step only while flush is shown.
  logic [N_STEPS-1:0] splan = '0;
  int fidx = 0;
  always @(negedge clock) begin
    if (start) fidx = 0;
    if (sip_flush) begin
      sip_spike = (fidx < N_STEPS) ? splan[fidx] : 1'b0;
      fidx++;
    end else begin
      sip_spike = 1'($urandom);
    end
  end

  frame_t cur;
  logic prev_write = 1'b0;
  int msel = 0;
  int done_cnt = 0;
  int sdone_cnt = 0;
  res_t r;

  always @(negedge clock) begin
    if (sip_write) begin
      if (!prev_write) begin
        chk("frame_available", 64'(fq.size() != 0), 64'd1);
        if (fq.size() != 0) cur = fq.pop_front();
        msel = 0;
      end
      chk("select_seq", 64'(sip_select), 64'(msel));
      chk("spike_in_held", 64'(sip_spike_in), 64'(cur.sp));
      chk("ein_held", 64'(sip_ein), 64'(cur.en));
      chk("scan_busy_ready", 64'({busy, frame_ready}), 64'b10);
      msel++;
    end else begin
      chk("select_zero_outside_scan", 64'(sip_select), 64'd0);
    end
    if (sip_flush) chk("scan_length", 64'(msel), 64'(N_SYN));
    prev_write = sip_write;
    if (done) begin
      chk("done_expected", 64'(dq.size() != 0), 64'd1);
      if (dq.size() != 0) begin
        r = dq.pop_front();
        chk("done_train", 64'(spike_train), 64'(r.train));
        chk("done_count", 64'(spike_count), 64'(r.count));
        chk("done_cycle", 64'(cyc), 64'(r.cyc));
      end
      done_cnt++;
    end
    if (s_done) begin
      chk("sat_done_expected", 64'(sq.size() != 0), 64'd1);
      if (sq.size() != 0) begin
        r = sq.pop_front();
        chk("sat_train", 64'(s_train), 64'(r.train));
        chk("sat_count", 64'(s_count), 64'(r.count));
        chk("sat_cycle", 64'(cyc), 64'(r.cyc));
      end
      sdone_cnt++;
    end
  end

  function automatic logic [3:0] sat_pop(input logic [15:0] bits);
    int c = $countones(bits);
    return (c > 15) ? 4'd15 : 4'(c);
  endfunction

  // mode: 0 normal, 1 abort at select 7 of step intr, 2 reset during flush of step intr
  task automatic run(input logic [N_STEPS-1:0] plan, input bit fixed, input int stall_step,
                     input int stall_len, input int mode, input int intr);
    int S, t, d0;
    logic [N_SYN-1:0] sp, en;
    res_t e;
    splan = plan;
    d0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    S = cyc;
    start = 1'b0;
    chk("start_clears", 64'({spike_train, spike_count, step_idx}), 64'd0);
    chk("start_load", 64'({busy, frame_ready, sip_write}), 64'b110);
    if (mode == 0) begin
      e.train = 16'(plan);
      e.count = sat_pop(16'(plan));
      e.cyc   = S + N_STEPS * STEP_CYC + ((stall_step >= 0) ? stall_len : 0);
      dq.push_back(e);
    end
    for (int k = 0; k < N_STEPS; k++) begin
      t = 0;
      @(negedge clock);
      while (!frame_ready && t < 100) begin @(negedge clock); t++; end
      if (!frame_ready) begin chk("ready_timeout", 64'(frame_ready), 64'd1); return; end
      if (k == stall_step) begin
        frame_valid = 1'b0;
        repeat (stall_len) begin
          chk("stall_ready_high", 64'(frame_ready), 64'd1);
          chk("stall_write_low", 64'(sip_write), 64'd0);
          @(negedge clock);
        end
      end
      sp = fixed ? 16'hAAAA : N_SYN'($urandom);
      en = fixed ? 16'hFFF0 : N_SYN'($urandom);
      if (k == stall_step) sp = 16'hD55D;
      frame_spike = sp;
      frame_ein   = en;
      frame_valid = 1'b1;
      @(posedge clock);
      fq.push_back('{sp, en});
      #1;
      frame_spike = N_SYN'($urandom);
      frame_ein   = N_SYN'($urandom);
      if (mode == 1 && k == intr) begin
        t = 0;
        @(negedge clock);
        while (!(sip_write && sip_select == 4'd7) && t < 40) begin @(negedge clock); t++; end
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        chk("abort_idle", 64'({busy, sip_write, frame_ready, sip_flush, done, sip_select}), 64'd0);
        chk("abort_partial_train", 64'(spike_train), 64'(plan & 8'h0F));
        chk("abort_partial_count", 64'(spike_count), 64'(sat_pop(16'(plan & 8'h0F))));
        repeat (3) @(negedge clock);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        return;
      end
      if (mode == 2 && k == intr) begin
        t = 0;
        @(negedge clock);
        while (!sip_flush && t < 40) begin @(negedge clock); t++; end
        reset = 1'b0;
        #1;
        chk("reset_ctrl_zero", 64'({frame_ready, sip_write, sip_select, sip_flush, busy, done,
                                    step_idx, spike_train, spike_count}), 64'd0);
        chk("reset_data_zero", 64'({sip_spike_in, sip_ein}), 64'd0);
        start = 1'b1;
        repeat (2) @(negedge clock);
        chk("start_ignored_in_reset", 64'({busy, frame_ready, sip_write}), 64'd0);
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_after_reset", 64'({busy, frame_ready, done}), 64'd0);
        return;
      end
    end
    t = 0;
    while (done_cnt == d0 && t < 400) begin @(negedge clock); t++; end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    @(negedge clock);
    chk("done_one_cycle", 64'({done, busy}), 64'd0);
  endtask

  initial begin
    int t;
    res_t e;
    reset = 1'b0; start = 1'b0; abort = 1'b0; start_s = 1'b0;
    frame_valid = 1'b0; frame_spike = '0; frame_ein = '0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", 64'({frame_ready, sip_write, sip_select, sip_flush, busy, done,
                             step_idx, spike_train, spike_count}), 64'd0);
    chk("reset_data", 64'({sip_spike_in, sip_ein}), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run(8'h00, 1'b1, -1, 0, 0, -1);
    run(8'b1000_1010, 1'b0, -1, 0, 0, -1);
    run(N_STEPS'($urandom), 1'b0, 2, 5, 0, -1);
    run(N_STEPS'($urandom), 1'b0, -1, 0, 1, 4);
    run(N_STEPS'($urandom), 1'b0, -1, 0, 0, -1);
    run(N_STEPS'($urandom), 1'b0, -1, 0, 2, 2);
    run(N_STEPS'($urandom), 1'b0, -1, 0, 0, -1);
    for (int i = 0; i < 4; i++)
      run(N_STEPS'($urandom), 1'b0, $urandom_range(0, N_STEPS - 1), $urandom_range(0, 6), 0, -1);

    @(negedge clock);
    abort = 1'b1; start = 1'b1;
    @(negedge clock);
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", 64'({busy, frame_ready}), 64'd0);

    @(negedge clock);
    start_s = 1'b1;
    @(posedge clock);
    #1;
    start_s = 1'b0;
    e.train = 16'h7FFF;
    e.count = 4'd15;
    e.cyc   = cyc + S_STEPS * STEP_CYC;
    sq.push_back(e);
    t = 0;
    while (sdone_cnt == 0 && t < 600) begin @(negedge clock); t++; end
    chk("sat_done_seen", 64'(sdone_cnt), 64'd1);
    repeat (2) @(negedge clock);
    chk("sat_idle", 64'({s_busy, s_ready, s_write, s_flush, s_select}), 64'd0);

    chk("pending_results", 64'(dq.size()), 64'd0);
    chk("pending_frames", 64'(fq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sip_step_scheduler.md
Name: sip_step_scheduler

Overview:
Time-step controller for the synaptic input processor (SIP) datapath of the SNN core. Per inference it runs N_STEPS time steps. Each step:
- accepts one spike/excitatory-select frame over a valid/ready handshake,
- drives the SIP's write and select lines through all synapses serially,
- pulses a flush, then samples the neuron spike.

It accumulates the output spike train and count and signals completion to the top-level sequencer.

Parameters:
N_SYN, 16, synapses per frame (width of spike and Ein vectors)
SEL_W, 4, select width; N_SYN = 2**SEL_W
N_STEPS, 8, time steps per inference (>=1)
CNT_W, 4, spike_count width; must satisfy 2**CNT_W-1 >= N_STEPS

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin inference; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle
frame_valid  in  1  frame source has data
frame_ready  out  1  scheduler accepts frame
frame_spike  in  N_SYN  presynaptic spike vector for this step
frame_ein  in  N_SYN  per-synapse excitatory(1)/inhibitory(0) select
sip_write  out  1  SIP accumulate enable
sip_select  out  SEL_W  synapse index presented to SIP
sip_spike_in  out  N_SYN  latched spike vector to SIP
sip_ein  out  N_SYN  latched Ein vector to SIP
sip_flush  out  1  one-cycle end-of-step flush to SIP
sip_spike  in  1  neuron output spike from SIP
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at inference completion
step_idx  out  SEL_W  current time step (0..N_STEPS-1)
spike_train  out  N_STEPS  bit k = neuron spiked in step k
spike_count  out  CNT_W  number of steps with a spike

Behaviour:
- All outputs are registered. When reset is low, asynchronously:
  - state = IDLE;
  - all outputs = 0, including sip_spike_in, sip_ein, spike_train and spike_count.
- States: IDLE, LOAD, SCAN, FLUSH, DONE.
- IDLE:
  - busy=0, frame_ready=0.
  - On start=1, go to LOAD; clear step_idx, spike_train and spike_count in the same edge.
- LOAD:
  - frame_ready=1.
  - On frame_valid & frame_ready, latch frame_spike into sip_spike_in and frame_ein into sip_ein, set select counter to 0, go to SCAN.
  - With no valid, wait indefinitely with frame_ready held.
- SCAN:
  - sip_write=1, frame_ready=0.
  - sip_select takes 0,1,...,N_SYN-1 on consecutive cycles, exactly N_SYN cycles.
  - After index N_SYN-1, go to FLUSH. The select counter wraps to 0 and does not run further.
  - sip_spike_in and sip_ein are held stable throughout SCAN.
- FLUSH (1 cycle):
  - sip_write=0, sip_flush=1.
  - Sample sip_spike: spike_train[step_idx] <= sip_spike; spike_count increments if sip_spike=1. spike_count saturates at 2**CNT_W-1 and never wraps.
  - If step_idx == N_STEPS-1, go to DONE; otherwise step_idx+1 and go to LOAD.
- DONE (1 cycle):
  - done=1; go to IDLE.
  - spike_train and spike_count hold until the next start.
- Latency:
  - With frame_valid held high, each step takes 1 (LOAD) + N_SYN (SCAN) + 1 (FLUSH) = 18 cycles at defaults.
  - start to done = 1 + N_STEPS*18 cycles = 145 at defaults. done is asserted in cycle 145 after the start edge.
- start while busy is ignored.
- abort has priority over every transition:
  - next state is IDLE; sip_write, sip_flush and frame_ready go to 0 the next cycle;
  - done is not pulsed;
  - spike_train and spike_count keep partial values;
  - a frame offered in the abort cycle is not consumed.
- abort and start in the same IDLE cycle: abort wins and the scheduler stays in IDLE.
- Reset asserted mid-SCAN: outputs clear immediately. After release the block waits in IDLE for start.
- sip_select is 0 outside SCAN.

Test Plan:
- Basic inference:
  - Stimulus: reset low 2 cycles then high; start pulse; frame_valid=1 constant; frame_spike=16'hAAAA, frame_ein=16'hFFF0; sip_spike tied 0.
  - Required: sip_select runs 0..15 for 8 steps; 8 sip_flush pulses; done in cycle 145; spike_count=0, spike_train=8'h00.
- Spike capture:
  - Stimulus: sip_spike=1 only during FLUSH of steps 1, 3 and 7.
  - Required: spike_train=8'b1000_1010, spike_count=3 at done.
- Backpressure:
  - Stimulus: frame_valid deasserted for 5 cycles before step 2; frame_spike changed to 16'hD55D for step 2.
  - Required: frame_ready stays high and sip_write stays 0 while waiting; sip_spike_in=16'hD55D throughout step 2 SCAN; done arrives 5 cycles later (cycle 150).
- Abort:
  - Stimulus: abort at SCAN select=7 of step 4.
  - Required: next cycle state IDLE, busy=0, sip_write=0, no done; a following start runs a full 145-cycle inference with spike_train cleared.
- Reset mid-operation:
  - Stimulus: reset low during step 2 FLUSH.
  - Required: all outputs 0 immediately; start ignored while reset is low; normal run after release.
- Saturation:
  - Stimulus: N_STEPS=15, CNT_W=4, sip_spike=1 constant.
  - Required: spike_count=15 with no wrap; spike_train=15'h7FFF.
